// File: rtl/regpair_incdec_if.sv
// Request/response bundle between a requester and regpair_incdec.
// The o_* signals also carry the write-back to the register file's 8-bit load port.
interface regpair_incdec_if;
    logic        i_start;
    logic        i_dec;
    logic [2:0]  i_pair_sel;
    logic [15:0] i_addr;
    logic [2:0]  o_addr_sel;
    logic        o_load;
    logic [3:0]  o_load_reg_sel;
    logic [7:0]  o_dat;
    logic        o_busy;
    logic        o_done;
    logic        o_wrap;
    logic        o_err;

    modport master (
        output i_start, i_dec, i_pair_sel, i_addr,
        input  o_addr_sel, o_load, o_load_reg_sel, o_dat,
        input  o_busy, o_done, o_wrap, o_err
    );

    modport slave (
        input  i_start, i_dec, i_pair_sel, i_addr,
        output o_addr_sel, o_load, o_load_reg_sel, o_dat,
        output o_busy, o_done, o_wrap, o_err
    );
endinterface

// File: rtl/regpair_incdec.sv
// Sequenced 16-bit +/-STEP on one register pair: select, capture, then write
// the result back as lo byte followed by hi byte through the 8-bit load port.
module regpair_incdec #(
    parameter int unsigned STEP  = 1,
    parameter int unsigned PAIRS = 6
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    regpair_incdec_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CAPT  = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic       dec;
        logic [2:0] pair;
    } req_t;

    localparam logic [15:0] STEP16 = 16'(STEP);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [15:0] res_q, res_d;
    logic        wrap_q, wrap_d;

    logic [2:0]  addr_sel_q, addr_sel_d;
    logic        load_q, load_d;
    logic [3:0]  reg_sel_q, reg_sel_d;
    logic [7:0]  dat_q, dat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wrap_out_q, wrap_out_d;
    logic        err_q, err_d;

    logic [16:0] sum17;
    logic [15:0] diff16;
    logic        borrow;
    logic        pair_ok;
    logic [15:0] calc_res;
    logic        calc_wrap;

    // Subtraction is done as two's-complement add; borrow is simply addr < STEP.
    always_comb begin
        sum17     = 17'(bus.i_addr) + 17'(STEP16);
        diff16    = bus.i_addr + (~STEP16 + 16'd1);
        borrow    = (bus.i_addr < STEP16);
        calc_res  = req_q.dec ? diff16 : sum17[15:0];
        calc_wrap = req_q.dec ? borrow : sum17[16];
        pair_ok   = (32'(bus.i_pair_sel) < PAIRS);
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        res_d      = res_q;
        wrap_d     = wrap_q;
        addr_sel_d = addr_sel_q;
        load_d     = 1'b0;
        reg_sel_d  = reg_sel_q;
        dat_d      = dat_q;
        done_d     = 1'b0;
        wrap_out_d = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (pair_ok) begin
                        req_d      = '{dec: bus.i_dec, pair: bus.i_pair_sel};
                        addr_sel_d = bus.i_pair_sel;
                        state_d    = CAPT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CAPT: begin
                res_d     = calc_res;
                wrap_d    = calc_wrap;
                load_d    = 1'b1;
                reg_sel_d = {req_q.pair, 1'b0};
                dat_d     = calc_res[7:0];
                state_d   = WR_LO;
            end
            WR_LO: begin
                load_d    = 1'b1;
                reg_sel_d = {req_q.pair, 1'b1};
                dat_d     = res_q[15:8];
                state_d   = WR_HI;
            end
            WR_HI: begin
                done_d     = 1'b1;
                wrap_out_d = wrap_q;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            res_q      <= '0;
            wrap_q     <= 1'b0;
            addr_sel_q <= '0;
            load_q     <= 1'b0;
            reg_sel_q  <= '0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_out_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            res_q      <= res_d;
            wrap_q     <= wrap_d;
            addr_sel_q <= addr_sel_d;
            load_q     <= load_d;
            reg_sel_q  <= reg_sel_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wrap_out_q <= wrap_out_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_addr_sel     = addr_sel_q;
    assign bus.o_load         = load_q;
    assign bus.o_load_reg_sel = reg_sel_q;
    assign bus.o_dat          = dat_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_wrap         = wrap_out_q;
    assign bus.o_err          = err_q;

endmodule
